// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Bit-order selectors for the MSB_FIRST parameter.
   localparam bit LSB_FIRST = 1'b0;
   localparam bit MSB_FIRST = 1'b1;

   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; strobes complete_o on the bit that fills a word
// and presents the post-shift contents on word_o in that same cycle.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = LSB_FIRST
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush_i,
   input  logic                        d_i,
   input  logic                        d_valid_i,
   output logic [WIDTH-1:0]            q_o,
   output logic [cnt_width(WIDTH)-1:0] cnt_o,
   output logic                        complete_o,
   output logic [WIDTH-1:0]            word_o
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d, shifted;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], d_i};
      else           shifted = {d_i, sr_q[WIDTH-1:1]};
   end

   // Flush outranks an incoming bit: the bit is dropped with the partial word.
   always_comb begin
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      complete_o = 1'b0;
      if (flush_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (d_valid_i) begin
         sr_d       = shifted;
         complete_o = (cnt_q == LAST);
         cnt_d      = complete_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign q_o    = sr_q;
   assign cnt_o  = cnt_q;
   assign word_o = shifted;

endmodule

// File: rtl/sipo_deserializer.sv
// Deserializer top: assembles words in the shift core and hands them downstream
// through a one-deep valid/ready holding register with sticky overrun.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = LSB_FIRST
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        d,
   input  logic                        d_valid,
   input  logic                        flush,
   output logic [WIDTH-1:0]            q,
   output logic [cnt_width(WIDTH)-1:0] bit_cnt,
   output logic [WIDTH-1:0]            word,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic                        overrun
);

   logic             complete;
   logic [WIDTH-1:0] new_word;
   logic [WIDTH-1:0] word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             overrun_q, overrun_d;
   logic             accept;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush),
      .d_i        (d),
      .d_valid_i  (d_valid),
      .q_o        (q),
      .cnt_o      (bit_cnt),
      .complete_o (complete),
      .word_o     (new_word)
   );

   assign accept = word_valid_q & word_ready;

   // A word completing while the held one is being consumed replaces it with no bubble.
   always_comb begin
      word_d       = word_q;
      word_valid_d = word_valid_q;
      overrun_d    = overrun_q;
      if (complete) begin
         if (!word_valid_q || word_ready) begin
            word_d       = new_word;
            word_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         word_valid_d = 1'b0;
      end
      if (flush) overrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q       <= '0;
         word_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: three configurations share one directed stimulus
// stream and are checked every cycle against a bit-history model plus literal values.
module tb_sipo_deserializer;

   logic clk = 1'b0;
   logic reset, d, d_valid, flush, word_ready;

   logic [7:0] q0, w0, q1, w1;
   logic [2:0] c0, c1;
   logic [3:0] q2, w2;
   logic [1:0] c2;
   logic       v0, o0, v1, o1, v2, o2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .flush(flush),
      .q(q0), .bit_cnt(c0), .word(w0), .word_valid(v0), .word_ready(word_ready), .overrun(o0));
   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .flush(flush),
      .q(q1), .bit_cnt(c1), .word(w1), .word_valid(v1), .word_ready(word_ready), .overrun(o1));
   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut2 (
      .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .flush(flush),
      .q(q2), .bit_cnt(c2), .word(w2), .word_valid(v2), .word_ready(word_ready), .overrun(o2));

   // Model: every accepted bit since the last clear, newest last.
   bit         hist [3][512];
   int         m_n   [3];
   logic [7:0] m_word[3];
   bit         m_wv  [3];
   bit         m_ovr [3];
   bit         started = 1'b0;

   function automatic int mw(input int i);
      return (i == 2) ? 4 : 8;
   endfunction

   function automatic bit mm(input int i);
      return (i == 1);
   endfunction

   // Last mw(i) bits placed by arrival order: newest at the top (LSB-first) or bottom (MSB-first).
   function automatic logic [7:0] qval(input int i);
      logic [7:0] r;
      r = '0;
      for (int j = 0; j < mw(i); j++) begin
         if (j < m_n[i]) begin
            if (mm(i)) r[j] = hist[i][m_n[i]-1-j];
            else       r[mw(i)-1-j] = hist[i][m_n[i]-1-j];
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            m_n[i] = 0; m_word[i] = '0; m_wv[i] = 1'b0; m_ovr[i] = 1'b0;
         end else if (started) begin
            bit acc, comp;
            logic [7:0] nw;
            acc  = m_wv[i] && word_ready;
            comp = 1'b0;
            nw   = '0;
            if (flush) begin
               m_n[i] = 0; m_ovr[i] = 1'b0;
            end else if (d_valid) begin
               hist[i][m_n[i]] = d;
               m_n[i]++;
               if (m_n[i] % mw(i) == 0) begin comp = 1'b1; nw = qval(i); end
            end
            if (comp) begin
               if (!m_wv[i] || word_ready) begin m_word[i] = nw; m_wv[i] = 1'b1; end
               else m_ovr[i] = 1'b1;
            end else if (acc) m_wv[i] = 1'b0;
         end
      end
      if (reset) started = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   logic [7:0] aq[3], aw[3];
   logic [2:0] ac[3];
   logic       av[3], ao[3];

   always_comb begin
      aq[0] = q0; aq[1] = q1; aq[2] = {4'b0, q2};
      aw[0] = w0; aw[1] = w1; aw[2] = {4'b0, w2};
      ac[0] = c0; ac[1] = c1; ac[2] = {1'b0, c2};
      av[0] = v0; av[1] = v1; av[2] = v2;
      ao[0] = o0; ao[1] = o1; ao[2] = o2;
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("q[%0d]", i),          32'(aq[i]), 32'(qval(i)));
            chk($sformatf("bit_cnt[%0d]", i),    32'(ac[i]), 32'(m_n[i] % mw(i)));
            chk($sformatf("word[%0d]", i),       32'(aw[i]), 32'(m_word[i]));
            chk($sformatf("word_valid[%0d]", i), 32'(av[i]), 32'(m_wv[i]));
            chk($sformatf("overrun[%0d]", i),    32'(ao[i]), 32'(m_ovr[i]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      d = b; d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
   endtask

   task automatic idle();
      d_valid = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int k = 0; k < 8; k++) send_bit(v[k]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; d = 1'b0; d_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("reset word", 32'(w0), 32'h0);
      chk("reset valid", 32'(v0), 32'h0);

      // Plain assembly, both bit orders.
      send_byte(8'h4D);
      chk("lsb word", 32'(w0), 32'h4D);
      chk("lsb valid", 32'(v0), 32'h1);
      chk("lsb bit_cnt", 32'(c0), 32'h0);
      chk("msb word", 32'(w1), 32'hB2);
      idle();
      chk("valid one cycle", 32'(v0), 32'h0);

      // Backpressure and overrun.
      do_reset();
      word_ready = 1'b0;
      send_byte(8'h4D);
      send_byte(8'hFF);
      chk("bp word held", 32'(w0), 32'h4D);
      chk("bp overrun", 32'(o0), 32'h1);
      word_ready = 1'b1;
      idle();
      word_ready = 1'b0;
      chk("bp drained", 32'(v0), 32'h0);
      chk("bp overrun sticky", 32'(o0), 32'h1);

      // Completion coincides with consumption of the held word.
      do_reset();
      send_byte(8'h3C);
      for (int k = 0; k < 7; k++) send_bit(k == 0 || k == 2 || k == 5);
      word_ready = 1'b1;
      send_bit(1'b1);
      chk("simul word", 32'(w0), 32'hA5);
      chk("simul valid", 32'(v0), 32'h1);
      chk("simul overrun", 32'(o0), 32'h0);
      idle();

      // Flush mid-word discards the bit presented with it.
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      d = 1'b1; d_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; d_valid = 1'b0;
      chk("flush bit_cnt", 32'(c0), 32'h0);
      chk("flush q", 32'(q0), 32'h0);
      send_byte(8'h96);
      chk("post-flush word", 32'(w0), 32'h96);
      chk("post-flush msb word", 32'(w1), 32'h69);

      // Reset while a word is held.
      chk("pre-reset valid", 32'(v0), 32'h1);
      do_reset();
      chk("rst q", 32'(q0), 32'h0);
      chk("rst bit_cnt", 32'(c0), 32'h0);
      chk("rst word", 32'(w0), 32'h0);
      chk("rst valid", 32'(v0), 32'h0);
      chk("rst overrun", 32'(o0), 32'h0);

      // Gapped input on the 4-bit instance.
      send_bit(1'b1);
      idle();
      chk("gap q idle", 32'(q2), 32'h8);
      send_bit(1'b1); idle();
      send_bit(1'b0); idle();
      send_bit(1'b1);
      chk("gap word", 32'(w2), 32'hB);
      chk("gap valid", 32'(v2), 32'h1);
      idle();
      chk("gap word kept", 32'(w2), 32'hB);
      chk("gap drained", 32'(v2), 32'h0);

      idle(); idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
